ibex_mem_bridge: RTL and testbench

- Sits directly downstream of the Ibex core's instruction or data memory port.
- Converts the core's req/gnt/rvalid protocol into a registered valid/ready request channel (A) and an in-order response channel (D) toward the SoC interconnect adapter.
- Enforces an outstanding-transaction limit, so responses are never presented to the core without a slot reserved for them.
- One instance per port, instruction or data.

---
 rtl/ibex_mem_bridge.sv | 135 +++++++++++++
 tb/tb_ibex_mem_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_mem_bridge.sv
// Bridge from the Ibex req/gnt/rvalid port to a registered valid/ready A channel and in-order D channel.
// Optional statistics counters are enabled with the IBEX_MEM_BRIDGE_STATS_EN macro.
module ibex_mem_bridge #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  output logic                gnt_o,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o,
  output logic                a_valid_o,
  input  logic                a_ready_i,
  output logic [ADDR_W-1:0]   a_addr_o,
  output logic                a_we_o,
  output logic [DATA_W/8-1:0] a_be_o,
  output logic [DATA_W-1:0]   a_wdata_o,
  input  logic                d_valid_i,
  output logic                d_ready_o,
  input  logic [DATA_W-1:0]   d_rdata_i,
  input  logic                d_err_i,
  output logic [CNT_W-1:0]    outstanding_o,
  output logic                spurious_o,
  output logic [31:0]         req_count_o,
  output logic [31:0]         err_count_o
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              a_valid_q, a_valid_d;
  logic [ADDR_W-1:0] a_addr_q;
  logic              a_we_q;
  logic [BE_W-1:0]   a_be_q;
  logic [DATA_W-1:0] a_wdata_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              spurious_q, spurious_d;
  logic              gnt, d_ready, d_hs;

  // Credit check uses only the registered count, so a same-cycle D beat never
  // frees a credit combinationally (no d_valid -> gnt path).
  always_comb begin
    gnt        = req_i & (~a_valid_q | a_ready_i) & (cnt_q < MAX_CNT);
    d_ready    = (cnt_q != '0);
    d_hs       = d_valid_i & d_ready;
    cnt_d      = cnt_q;
    a_valid_d  = a_valid_q;
    spurious_d = spurious_q | (d_valid_i & ~d_ready);
    if (gnt && !d_hs) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!gnt && d_hs) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (gnt) begin
      a_valid_d = 1'b1;
    end else if (a_ready_i) begin
      a_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      a_valid_q  <= 1'b0;
      a_addr_q   <= '0;
      a_we_q     <= 1'b0;
      a_be_q     <= '0;
      a_wdata_q  <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      a_valid_q  <= a_valid_d;
      rvalid_q   <= d_hs;
      spurious_q <= spurious_d;
      if (gnt) begin
        a_addr_q  <= addr_i;
        a_we_q    <= we_i;
        a_be_q    <= be_i;
        a_wdata_q <= wdata_i;
      end
      if (d_hs) begin
        rdata_q <= d_rdata_i;
        err_q   <= d_err_i;
      end
    end
  end

`ifdef IBEX_MEM_BRIDGE_STATS_EN
  logic [31:0] req_cnt_q, err_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (gnt) req_cnt_q <= req_cnt_q + 32'd1;
      if (rvalid_q && err_q) err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign req_count_o = req_cnt_q;
  assign err_count_o = err_cnt_q;
`else
  assign req_count_o = '0;
  assign err_count_o = '0;
`endif

  assign gnt_o         = gnt;
  assign d_ready_o     = d_ready;
  assign a_valid_o     = a_valid_q;
  assign a_addr_o      = a_addr_q;
  assign a_we_o        = a_we_q;
  assign a_be_o        = a_be_q;
  assign a_wdata_o     = a_wdata_q;
  assign rvalid_o      = rvalid_q;
  assign rdata_o       = rdata_q;
  assign err_o         = err_q;
  assign outstanding_o = cnt_q;
  assign spurious_o    = spurious_q;

endmodule

// File: tb/tb_ibex_mem_bridge.sv
// Directed bench for ibex_mem_bridge: cycle table for the main flow, hand sequences for corner cases.
module tb_ibex_mem_bridge;

`ifdef IBEX_MEM_BRIDGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i, gnt_o, we_i, rvalid_o, err_o;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic [3:0]  be_i;
  logic        a_valid_o, a_ready_i, a_we_o;
  logic [31:0] a_addr_o, a_wdata_o;
  logic [3:0]  a_be_o;
  logic        d_valid_i, d_ready_o, d_err_i;
  logic [31:0] d_rdata_i;
  logic [1:0]  outstanding_o;
  logic        spurious_o;
  logic [31:0] req_count_o, err_count_o;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int hs0;

  always #5 clk = ~clk;

  always @(posedge clk) if (a_valid_o && a_ready_i) hs_cnt <= hs_cnt + 1;

  ibex_mem_bridge dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .a_valid_o(a_valid_o), .a_ready_i(a_ready_i), .a_addr_o(a_addr_o),
    .a_we_o(a_we_o), .a_be_o(a_be_o), .a_wdata_o(a_wdata_o), .d_valid_i(d_valid_i),
    .d_ready_o(d_ready_o), .d_rdata_i(d_rdata_i), .d_err_i(d_err_i),
    .outstanding_o(outstanding_o), .spurious_o(spurious_o),
    .req_count_o(req_count_o), .err_count_o(err_count_o)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        a_ready;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        x_gnt;
    logic        x_a_valid;
    logic [31:0] x_a_addr;
    logic        x_d_ready;
    logic        x_rvalid;
    logic [31:0] x_rdata;
    logic        x_err;
    logic [1:0]  x_out;
    int          x_reqc;
    int          x_errc;
  } vec_t;

  vec_t vec[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_i = 0; addr_i = 0; we_i = 0; be_i = 0; wdata_i = 0;
    a_ready_i = 1; d_valid_i = 0; d_rdata_i = 0; d_err_i = 0;
  endtask

  initial begin
    //          req addr        ar dv d_rdata      de | gnt av a_addr     dr rv rdata        er out reqc errc
    vec[0]  = '{1, 32'h8000_0000, 1, 0, 32'h0,        0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0};
    vec[1]  = '{0, 32'h0,         1, 0, 32'h0,        0, 0, 1, 32'h8000_0000, 1, 0, 32'h0,        0, 1, 1, 0};
    vec[2]  = '{0, 32'h0,         1, 0, 32'h0,        0, 0, 0, 32'h8000_0000, 1, 0, 32'h0,        0, 1, 1, 0};
    vec[3]  = '{0, 32'h0,         1, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'h8000_0000, 1, 0, 32'h0,        0, 1, 1, 0};
    vec[4]  = '{0, 32'h0,         1, 0, 32'h0,        0, 0, 0, 32'h8000_0000, 0, 1, 32'hDEAD_BEEF, 0, 0, 1, 0};
    vec[5]  = '{0, 32'h0,         1, 0, 32'h0,        0, 0, 0, 32'h8000_0000, 0, 0, 32'hDEAD_BEEF, 0, 0, 1, 0};
    vec[6]  = '{1, 32'h100,       1, 0, 32'h0,        0, 1, 0, 32'h8000_0000, 0, 0, 32'hDEAD_BEEF, 0, 0, 1, 0};
    vec[7]  = '{1, 32'h104,       1, 0, 32'h0,        0, 1, 1, 32'h100,       1, 0, 32'hDEAD_BEEF, 0, 1, 2, 0};
    vec[8]  = '{1, 32'h108,       1, 0, 32'h0,        0, 0, 1, 32'h104,       1, 0, 32'hDEAD_BEEF, 0, 2, 3, 0};
    vec[9]  = '{1, 32'h108,       1, 0, 32'h0,        0, 0, 0, 32'h104,       1, 0, 32'hDEAD_BEEF, 0, 2, 3, 0};
    vec[10] = '{1, 32'h108,       1, 1, 32'h1111_1111, 0, 0, 0, 32'h104,       1, 0, 32'hDEAD_BEEF, 0, 2, 3, 0};
    vec[11] = '{1, 32'h108,       1, 0, 32'h0,        0, 1, 0, 32'h104,       1, 1, 32'h1111_1111, 0, 1, 3, 0};
    vec[12] = '{0, 32'h0,         1, 1, 32'h2222_2222, 0, 0, 1, 32'h108,       1, 0, 32'h1111_1111, 0, 2, 4, 0};
    vec[13] = '{1, 32'h10C,       1, 1, 32'h3333_3333, 1, 1, 0, 32'h108,       1, 1, 32'h2222_2222, 0, 1, 4, 0};
    vec[14] = '{0, 32'h0,         1, 0, 32'h0,        0, 0, 1, 32'h10C,       1, 1, 32'h3333_3333, 1, 1, 5, 0};
    vec[15] = '{0, 32'h0,         1, 1, 32'h4444_4444, 0, 0, 0, 32'h10C,       1, 0, 32'h3333_3333, 1, 1, 5, 1};
    vec[16] = '{0, 32'h0,         1, 0, 32'h0,        0, 0, 0, 32'h10C,       0, 1, 32'h4444_4444, 0, 0, 5, 1};

    rst_i = 1;
    idle_inputs();
    #2;
    check("rst a_valid", 32'(a_valid_o), 32'd0);
    check("rst outstanding", 32'(outstanding_o), 32'd0);
    check("rst rvalid", 32'(rvalid_o), 32'd0);
    check("rst spurious", 32'(spurious_o), 32'd0);
    @(negedge clk);
    rst_i = 0;

    // table: single read, credit limit, simultaneous grant/response, error response
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      req_i = vec[i].req; addr_i = vec[i].addr; a_ready_i = vec[i].a_ready;
      d_valid_i = vec[i].d_valid; d_rdata_i = vec[i].d_rdata; d_err_i = vec[i].d_err;
      we_i = 0; be_i = 0; wdata_i = 0;
      #1;
      check($sformatf("v%0d gnt", i), 32'(gnt_o), 32'(vec[i].x_gnt));
      check($sformatf("v%0d a_valid", i), 32'(a_valid_o), 32'(vec[i].x_a_valid));
      check($sformatf("v%0d a_addr", i), a_addr_o, vec[i].x_a_addr);
      check($sformatf("v%0d d_ready", i), 32'(d_ready_o), 32'(vec[i].x_d_ready));
      check($sformatf("v%0d rvalid", i), 32'(rvalid_o), 32'(vec[i].x_rvalid));
      check($sformatf("v%0d rdata", i), rdata_o, vec[i].x_rdata);
      check($sformatf("v%0d err", i), 32'(err_o), 32'(vec[i].x_err));
      check($sformatf("v%0d outstanding", i), 32'(outstanding_o), 32'(vec[i].x_out));
      check($sformatf("v%0d req_count", i), req_count_o, STATS ? 32'(vec[i].x_reqc) : 32'd0);
      check($sformatf("v%0d err_count", i), err_count_o, STATS ? 32'(vec[i].x_errc) : 32'd0);
    end

    // backpressure: write held for 5 cycles, second request not granted
    @(negedge clk);
    idle_inputs();
    req_i = 1; we_i = 1; addr_i = 32'h200; be_i = 4'b0011; wdata_i = 32'h1234_5678; a_ready_i = 0;
    #1;
    check("bp first gnt", 32'(gnt_o), 32'd1);
    @(negedge clk);
    hs0 = hs_cnt;
    for (int c = 0; c < 5; c++) begin
      req_i = 1; we_i = 0; addr_i = 32'h204; be_i = 4'hF; wdata_i = 32'hAAAA_5555;
      #1;
      check($sformatf("bp%0d gnt", c), 32'(gnt_o), 32'd0);
      check($sformatf("bp%0d a_valid", c), 32'(a_valid_o), 32'd1);
      check($sformatf("bp%0d a_addr", c), a_addr_o, 32'h200);
      check($sformatf("bp%0d a_wdata", c), a_wdata_o, 32'h1234_5678);
      check($sformatf("bp%0d a_be", c), 32'(a_be_o), 32'h3);
      check($sformatf("bp%0d a_we", c), 32'(a_we_o), 32'd1);
      @(negedge clk);
    end
    check("bp no handshake while stalled", 32'(hs_cnt - hs0), 32'd0);
    req_i = 0; a_ready_i = 1;
    #1;
    check("bp a_valid at release", 32'(a_valid_o), 32'd1);
    @(negedge clk);
    #1;
    check("bp a_valid cleared", 32'(a_valid_o), 32'd0);
    check("bp single handshake", 32'(hs_cnt - hs0), 32'd1);
    check("bp outstanding", 32'(outstanding_o), 32'd1);
    d_valid_i = 1; d_rdata_i = 32'h5555_5555;
    #1;
    check("bp d_ready", 32'(d_ready_o), 32'd1);
    @(negedge clk);
    d_valid_i = 0;
    #1;
    check("bp rvalid", 32'(rvalid_o), 32'd1);
    check("bp rdata", rdata_o, 32'h5555_5555);
    check("bp outstanding drained", 32'(outstanding_o), 32'd0);
    check("bp req_count", req_count_o, STATS ? 32'd6 : 32'd0);

    // spurious response at cnt=0
    @(negedge clk);
    d_valid_i = 1; d_rdata_i = 32'h6666_6666;
    #1;
    check("sp d_ready", 32'(d_ready_o), 32'd0);
    @(negedge clk);
    d_valid_i = 0;
    #1;
    check("sp spurious", 32'(spurious_o), 32'd1);
    check("sp no rvalid", 32'(rvalid_o), 32'd0);
    check("sp rdata held", rdata_o, 32'h5555_5555);
    check("sp outstanding", 32'(outstanding_o), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("sp sticky", 32'(spurious_o), 32'd1);

    // reset mid-flight with two outstanding and A slot occupied
    @(negedge clk);
    req_i = 1; addr_i = 32'h400; a_ready_i = 1;
    @(negedge clk);
    addr_i = 32'h404;
    @(negedge clk);
    req_i = 0; a_ready_i = 0;
    #1;
    check("rm outstanding before", 32'(outstanding_o), 32'd2);
    check("rm a_valid before", 32'(a_valid_o), 32'd1);
    rst_i = 1;
    #1;
    check("rm a_valid", 32'(a_valid_o), 32'd0);
    check("rm a_addr", a_addr_o, 32'd0);
    check("rm outstanding", 32'(outstanding_o), 32'd0);
    check("rm spurious", 32'(spurious_o), 32'd0);
    check("rm rdata", rdata_o, 32'd0);
    check("rm req_count", req_count_o, 32'd0);
    check("rm err_count", err_count_o, 32'd0);
    @(negedge clk);
    rst_i = 0;
    idle_inputs();
    @(negedge clk);
    req_i = 1; addr_i = 32'h300;
    #1;
    check("rm gnt", 32'(gnt_o), 32'd1);
    @(negedge clk);
    req_i = 0;
    #1;
    check("rm a_valid after", 32'(a_valid_o), 32'd1);
    check("rm a_addr after", a_addr_o, 32'h300);
    check("rm outstanding after", 32'(outstanding_o), 32'd1);
    @(negedge clk);
    d_valid_i = 1; d_rdata_i = 32'h7777_7777;
    @(negedge clk);
    d_valid_i = 0;
    #1;
    check("rm rvalid", 32'(rvalid_o), 32'd1);
    check("rm rdata after", rdata_o, 32'h7777_7777);
    check("rm outstanding done", 32'(outstanding_o), 32'd0);
    @(negedge clk);
    #1;
    check("rm rvalid pulse", 32'(rvalid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
